pc_sequencer: RTL and testbench

//  Registered program-counter unit for the IF stage; successor to the combinational next-PC muxes.

---
 rtl/pc_sequencer.sv | 140 ++++++++++++++
 tb/tb_pc_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Registered IF-stage program counter: priority redirect arbitration, stall buffering and RUN/HALTED control.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_sequencer #(
   parameter int DataWidth   = 16,
   parameter int PCIncrement = 1,
   parameter int ResetVector = 0,
   parameter int RASDepth    = 4
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 Stall,
   input  logic                 Halt,
   input  logic                 PCOverwrite,
   input  logic [DataWidth-1:0] OverwriteAddress,
   input  logic                 TakeJump,
   input  logic [DataWidth-1:0] JumpTarget,
   input  logic                 TakeBranch,
   input  logic [DataWidth-1:0] BranchTarget,
   input  logic                 Call,
   input  logic                 Return,
   output logic [DataWidth-1:0] PC,
   output logic [DataWidth-1:0] NextPC,
   output logic                 Halted,
   output logic                 PendingValid,
   output logic                 RedirectPulse,
   output logic                 RASEmpty
);

   typedef enum logic {RUN, HALTED} state_t;

   state_t               state_q, state_d;
   logic [DataWidth-1:0] pc_q, seq_pc, target, pending_addr_q, pending_addr_d;
   logic                 pending_valid_q, pending_valid_d, pulse_d;
   logic                 ret_live, live, accept, do_push, do_pop;
   logic [DataWidth-1:0] ras_top;

   assign seq_pc = pc_q + DataWidth'(PCIncrement);
   assign accept = (state_q == RUN) && !PCOverwrite && !Halt;

   // A return only counts as a redirect when the stack has something to pop.
   assign ret_live = Return && !RASEmpty;
   assign live     = TakeJump || ret_live || TakeBranch;
   assign target   = TakeJump ? JumpTarget : (ret_live ? ras_top : BranchTarget);
   assign do_push  = accept && TakeJump && Call;
   assign do_pop   = accept && !TakeJump && ret_live;

   // FSM: state register
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state_q <= RUN;
      else       state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      // NOTE: assign a default first so every path drives state_d and no latch is inferred.
      state_d = state_q;
      if (PCOverwrite)                   state_d = RUN;
      else if (state_q == RUN && Halt)   state_d = HALTED;
   end

   // FSM: outputs
   always_comb begin
      Halted = (state_q == HALTED);
   end

   always_comb begin
      NextPC          = pc_q;
      pending_valid_d = 1'b0;
      pending_addr_d  = pending_addr_q;
      pulse_d         = 1'b0;
      if (PCOverwrite) begin
         NextPC  = OverwriteAddress;
         pulse_d = 1'b1;
      end else if (accept && Stall) begin
         pending_valid_d = pending_valid_q || live;
         if (live) pending_addr_d = target;
      end else if (accept) begin
         pulse_d = live || pending_valid_q;
         if (live)                 NextPC = target;
         else if (pending_valid_q) NextPC = pending_addr_q;
         else                      NextPC = seq_pc;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
         pc_q            <= DataWidth'(ResetVector);
         pending_valid_q <= 1'b0;
         pending_addr_q  <= '0;
         RedirectPulse   <= 1'b0;
      end else begin
         pc_q            <= NextPC;
         pending_valid_q <= pending_valid_d;
         pending_addr_q  <= pending_addr_d;
         RedirectPulse   <= pulse_d;
      end
   end

   assign PC           = pc_q;
   assign PendingValid = pending_valid_q;

`ifdef PC_RAS_EN
   localparam int PtrW = (RASDepth > 1) ? $clog2(RASDepth) : 1;

   logic [DataWidth-1:0] ras_mem [RASDepth];
   logic [PtrW-1:0]      ras_sp, sp_inc, sp_dec;
   logic [PtrW:0]        ras_count;

   // Pointer wraps explicitly so non-power-of-two depths stay circular.
   assign sp_inc   = (ras_sp == PtrW'(RASDepth - 1)) ? '0 : ras_sp + 1'b1;
   assign sp_dec   = (ras_sp == '0) ? PtrW'(RASDepth - 1) : ras_sp - 1'b1;
   assign ras_top  = ras_mem[sp_dec];
   assign RASEmpty = (ras_count == '0);

   // NOTE: stack storage is not reset; ras_count alone decides which entries are valid.
   always_ff @(posedge Clock) begin
      if (do_push) ras_mem[ras_sp] <= seq_pc;
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         ras_sp    <= '0;
         ras_count <= '0;
      end else if (do_push) begin
         ras_sp <= sp_inc;
         if (ras_count != (PtrW+1)'(RASDepth)) ras_count <= ras_count + 1'b1;
      end else if (do_pop) begin
         ras_sp    <= sp_dec;
         ras_count <= ras_count - 1'b1;
      end
   end
`else
   logic unused_ras;
   assign RASEmpty   = 1'b1;
   assign ras_top    = '0;
   assign unused_ras = Call ^ do_push ^ do_pop;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; the return-stack scenario runs when PC_RAS_EN is defined.
module tb_pc_sequencer;

   logic        Clock = 1'b0, Reset;
   logic        Stall, Halt, PCOverwrite, TakeJump, TakeBranch, Call, Return;
   logic [15:0] OverwriteAddress, JumpTarget, BranchTarget;
   logic [15:0] PC, NextPC;
   logic        Halted, PendingValid, RedirectPulse, RASEmpty;

   int checks = 0;
   int failures = 0;

   pc_sequencer #(.DataWidth(16), .PCIncrement(1), .ResetVector(0), .RASDepth(4)) dut (
      .Clock(Clock), .Reset(Reset), .Stall(Stall), .Halt(Halt),
      .PCOverwrite(PCOverwrite), .OverwriteAddress(OverwriteAddress),
      .TakeJump(TakeJump), .JumpTarget(JumpTarget),
      .TakeBranch(TakeBranch), .BranchTarget(BranchTarget),
      .Call(Call), .Return(Return),
      .PC(PC), .NextPC(NextPC), .Halted(Halted), .PendingValid(PendingValid),
      .RedirectPulse(RedirectPulse), .RASEmpty(RASEmpty)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      Stall = 0; Halt = 0; PCOverwrite = 0; TakeJump = 0; TakeBranch = 0;
      Call = 0; Return = 0; OverwriteAddress = '0; JumpTarget = '0; BranchTarget = '0;
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic overwrite(input logic [15:0] addr);
      idle(); PCOverwrite = 1; OverwriteAddress = addr;
      step(); idle();
   endtask

   initial begin
      idle();
      Reset = 1;
      step(); step();
      check("rst_pc", PC, 16'd0);
      check("rst_halted", Halted, 1'b0);
      check("rst_pending", PendingValid, 1'b0);
      check("rst_pulse", RedirectPulse, 1'b0);
      check("rst_ras_empty", RASEmpty, 1'b1);
      Reset = 0;

      // sequential count from reset
      for (int i = 1; i <= 5; i++) begin
         step();
         check("seq_pc", PC, 32'(i));
         check("seq_pulse", RedirectPulse, 1'b0);
      end

      // jump beats branch
      TakeBranch = 1; BranchTarget = 16'd10; TakeJump = 1; JumpTarget = 16'd78;
      #1 check("prio_nextpc", NextPC, 16'd78);
      step(); idle();
      check("prio_pc", PC, 16'd78);
      check("prio_pulse", RedirectPulse, 1'b1);
      step();
      check("after_jump_pc", PC, 16'd79);
      check("after_jump_pulse", RedirectPulse, 1'b0);

      // branch buffered during a two-cycle stall
      Stall = 1; TakeBranch = 1; BranchTarget = 16'd10;
      #1 check("stall_nextpc", NextPC, 16'd79);
      step(); idle(); Stall = 1;
      check("stall1_pc", PC, 16'd79);
      check("stall1_pending", PendingValid, 1'b1);
      step(); idle();
      check("stall2_pc", PC, 16'd79);
      check("stall2_pending", PendingValid, 1'b1);
      #1 check("unstall_nextpc", NextPC, 16'd10);
      step();
      check("unstall_pc", PC, 16'd10);
      check("unstall_pending", PendingValid, 1'b0);
      check("unstall_pulse", RedirectPulse, 1'b1);

      // later stalled redirect replaces pending
      Stall = 1; TakeBranch = 1; BranchTarget = 16'd20;
      step(); idle(); Stall = 1; TakeJump = 1; JumpTarget = 16'd30;
      step(); idle();
      step();
      check("replace_pc", PC, 16'd30);

      // live redirect beats pending on the unstall cycle
      Stall = 1; TakeBranch = 1; BranchTarget = 16'd90;
      step(); idle(); TakeBranch = 1; BranchTarget = 16'd95;
      step(); idle();
      check("live_over_pending", PC, 16'd95);

      // overwrite during stall loads and clears pending
      Stall = 1; TakeBranch = 1; BranchTarget = 16'd40;
      step(); idle(); Stall = 1; PCOverwrite = 1; OverwriteAddress = 16'd50;
      step(); idle();
      check("ovw_stall_pc", PC, 16'd50);
      check("ovw_stall_pending", PendingValid, 1'b0);
      step();
      check("ovw_stall_next", PC, 16'd51);

      // halt freezes PC and ignores jumps
      Halt = 1;
      step(); idle();
      check("halt_halted", Halted, 1'b1);
      check("halt_pc", PC, 16'd51);
      TakeJump = 1; JumpTarget = 16'd78; Stall = 1;
      step(); idle();
      check("halted_jump_pc", PC, 16'd51);
      check("halted_still", Halted, 1'b1);
      overwrite(16'd35);
      check("resume_pc", PC, 16'd35);
      check("resume_halted", Halted, 1'b0);
      check("resume_pulse", RedirectPulse, 1'b1);
      step();
      check("resume_next", PC, 16'd36);

      // halt and overwrite together: overwrite wins
      Halt = 1; PCOverwrite = 1; OverwriteAddress = 16'd100;
      step(); idle();
      check("halt_ovw_pc", PC, 16'd100);
      check("halt_ovw_halted", Halted, 1'b0);

      // halt discards a pending redirect
      Stall = 1; TakeBranch = 1; BranchTarget = 16'd7;
      step(); idle(); Halt = 1;
      step(); idle();
      check("halt_drop_pending", PendingValid, 1'b0);
      overwrite(16'd200);
      step();
      check("halt_drop_pc", PC, 16'd201);

      // wrap at the top of the address space
      overwrite(16'hFFFF);
      check("wrap_pre", PC, 16'hFFFF);
      step();
      check("wrap_pc", PC, 16'h0000);

`ifdef PC_RAS_EN
      overwrite(16'd4);
      TakeJump = 1; Call = 1; JumpTarget = 16'd78;
      step(); idle();
      check("call_pc", PC, 16'd78);
      check("call_ras_empty", RASEmpty, 1'b0);
      Return = 1;
      step(); idle();
      check("ret_pc", PC, 16'd5);
      check("ret_ras_empty", RASEmpty, 1'b1);
      check("ret_pulse", RedirectPulse, 1'b1);
      Return = 1;
      step(); idle();
      check("ret_empty_pc", PC, 16'd6);
      check("ret_empty_pulse", RedirectPulse, 1'b0);

      // five calls into a four-deep stack: the oldest return (7) is lost
      for (int i = 0; i < 5; i++) begin
         TakeJump = 1; Call = 1; JumpTarget = 16'(20 + 10 * i);
         step(); idle();
      end
      check("deep_pc", PC, 16'd60);
      for (int i = 0; i < 4; i++) begin
         Return = 1; TakeBranch = 1; BranchTarget = 16'd999;
         step(); idle();
         check("deep_ret_pc", PC, 32'(51 - 10 * i));
      end
      check("deep_ras_empty", RASEmpty, 1'b1);
`else
      overwrite(16'd4);
      Return = 1;
      step(); idle();
      check("noras_ret_pc", PC, 16'd5);
      TakeJump = 1; Call = 1; JumpTarget = 16'd78;
      step(); idle(); Return = 1;
      step(); idle();
      check("noras_call_ret_pc", PC, 16'd79);
      check("noras_ras_empty", RASEmpty, 1'b1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
